// File: rtl/dp_issue_ctrl.sv
// Issue sequencer for ARM data-processing instructions.
// Reads Rn/Rm, builds operand B, drives the ALU, retires result and flags.
module dp_issue_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [XLEN-1:0] instr,
  output logic [3:0]      rf_ra_addr,
  output logic [3:0]      rf_rb_addr,
  input  logic [XLEN-1:0] rf_ra_data,
  input  logic [XLEN-1:0] rf_rb_data,
  output logic            rf_we,
  output logic [3:0]      rf_wa,
  output logic [XLEN-1:0] rf_wd,
  output logic [XLEN-1:0] operand_a,
  output logic [XLEN-1:0] operand_b,
  output logic [3:0]      alu_control,
  output logic            alu_carry_in,
  input  logic [XLEN-1:0] result,
  input  logic            zero_flag,
  input  logic            carry_flag,
  input  logic            overflow_flag,
  input  logic            negative_flag,
  output logic [3:0]      nzcv,
  output logic            done,
  output logic            skipped,
  output logic            unsupported
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_READ = 2'd1;
  localparam logic [1:0] S_EXEC = 2'd2;
  localparam logic [1:0] S_WB   = 2'd3;

  logic [1:0]      state;
  logic [XLEN-1:0] ir;
  logic [XLEN-1:0] res_q;
  logic            wr_q;
  logic            skip_q;
  logic            unsup_q;

  logic [3:0]      op;
  logic            cond_ok;
  logic            bad_enc;
  logic            arith;
  logic            exec;
  logic [XLEN-1:0] sh_val;
  logic            sh_c;
  logic [32:0]     t33;

  function automatic logic [31:0] ror32(
    input logic [31:0] x,
    input logic [4:0]  r
  );
    return (x >> r) | (x << (6'd32 - {1'b0, r}));
  endfunction

  function automatic logic cond_pass(
    input logic [3:0] c,
    input logic [3:0] f
  );
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'h0:    return z;
      4'h1:    return !z;
      4'h2:    return cy;
      4'h3:    return !cy;
      4'h4:    return n;
      4'h5:    return !n;
      4'h6:    return v;
      4'h7:    return !v;
      4'h8:    return cy && !z;
      4'h9:    return !cy || z;
      4'hA:    return n == v;
      4'hB:    return n != v;
      4'hC:    return !z && (n == v);
      4'hD:    return z || (n != v);
      4'hE:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  assign op      = ir[24:21];
  assign exec    = (state == S_EXEC);
  assign cond_ok = cond_pass(ir[31:28], nzcv);
  assign bad_enc = (ir[27:26] != 2'b00)
                || (!ir[25] && ir[4])
                || ((op[3:2] == 2'b10) && !ir[20]);
  assign arith   = (op[3:2] == 2'b01)
                || (op[3:1] == 3'b001)
                || (op[3:1] == 3'b101);

  assign instr_ready  = (state == S_IDLE);
  assign rf_ra_addr   = ir[19:16];
  assign rf_rb_addr   = ir[3:0];
  assign rf_wa        = ir[15:12];
  assign rf_wd        = res_q;
  assign done         = (state == S_WB);
  assign rf_we        = done && wr_q;
  assign skipped      = done && skip_q;
  assign unsupported  = done && unsup_q;
  assign operand_a    = exec ? rf_ra_data : '0;
  assign operand_b    = exec ? sh_val : '0;
  assign alu_control  = exec ? op : 4'h0;
  assign alu_carry_in = exec && nzcv[1];

  // Barrel shifter: operand B and its carry-out
  always_comb begin
    sh_val = '0;
    sh_c   = nzcv[1];
    t33    = '0;
    if (ir[25]) begin
      sh_val = ror32({24'h0, ir[7:0]}, {ir[11:8], 1'b0});
      if (ir[11:8] != 4'h0) sh_c = sh_val[31];
    end else begin
      case (ir[6:5])
        2'b00: begin
          t33 = {1'b0, rf_rb_data} << ir[11:7];
          sh_val = t33[31:0];
          if (ir[11:7] != 5'd0) sh_c = t33[32];
        end
        2'b01: begin
          t33 = {rf_rb_data, 1'b0} >> ir[11:7];
          sh_val = (ir[11:7] == 5'd0) ? '0 : t33[32:1];
          sh_c = (ir[11:7] == 5'd0) ? rf_rb_data[31] : t33[0];
        end
        2'b10: begin
          t33 = 33'($signed({rf_rb_data, 1'b0}) >>> ir[11:7]);
          sh_val = (ir[11:7] == 5'd0) ? {32{rf_rb_data[31]}}
                                      : t33[32:1];
          sh_c = (ir[11:7] == 5'd0) ? rf_rb_data[31] : t33[0];
        end
        default: begin
          if (ir[11:7] == 5'd0) begin
            sh_val = {nzcv[1], rf_rb_data[31:1]};
            sh_c   = rf_rb_data[0];
          end else begin
            sh_val = ror32(rf_rb_data, ir[11:7]);
            sh_c   = sh_val[31];
          end
        end
      endcase
    end
  end

  // Sequencer state, latched instruction, result and flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      ir      <= '0;
      res_q   <= '0;
      wr_q    <= 1'b0;
      skip_q  <= 1'b0;
      unsup_q <= 1'b0;
      nzcv    <= 4'h0;
    end else begin
      case (state)
        S_IDLE: begin
          if (instr_valid) begin
            ir    <= instr;
            state <= S_READ;
          end
        end
        S_READ: begin
          skip_q  <= 1'b0;
          unsup_q <= 1'b0;
          wr_q    <= 1'b0;
          if (!cond_ok) begin
            skip_q <= 1'b1;
            state  <= S_WB;
          end else if (bad_enc) begin
            unsup_q <= 1'b1;
            state   <= S_WB;
          end else begin
            wr_q  <= (op[3:2] != 2'b10);
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          res_q <= result;
          if (ir[20]) begin
            if (arith)
              nzcv <= {negative_flag, zero_flag,
                       carry_flag, overflow_flag};
            else
              nzcv <= {negative_flag, zero_flag,
                       sh_c, nzcv[0]};
          end
          state <= S_WB;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dp_issue_ctrl.sv
// Testbench for dp_issue_ctrl.
// Register-file and ALU stubs, vector table and scoreboard.
module tb_dp_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [3:0]  rf_ra_addr, rf_rb_addr;
  logic [31:0] rf_ra_data, rf_rb_data;
  logic        rf_we;
  logic [3:0]  rf_wa;
  logic [31:0] rf_wd;
  logic [31:0] operand_a, operand_b;
  logic [3:0]  alu_control;
  logic        alu_carry_in;
  logic [31:0] result;
  logic        zero_flag, carry_flag;
  logic        overflow_flag, negative_flag;
  logic [3:0]  nzcv;
  logic        done, skipped, unsupported;

  dp_issue_ctrl #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr),
    .rf_ra_addr(rf_ra_addr), .rf_rb_addr(rf_rb_addr),
    .rf_ra_data(rf_ra_data), .rf_rb_data(rf_rb_data),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
    .operand_a(operand_a), .operand_b(operand_b),
    .alu_control(alu_control), .alu_carry_in(alu_carry_in),
    .result(result),
    .zero_flag(zero_flag), .carry_flag(carry_flag),
    .overflow_flag(overflow_flag),
    .negative_flag(negative_flag),
    .nzcv(nzcv), .done(done),
    .skipped(skipped), .unsupported(unsupported)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic        we;
    logic [3:0]  wa;
    logic [31:0] wd;
    logic [3:0]  nzcv;
    logic        skp;
    logic        uns;
    int          lat;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   stamp_q[$];
  vec_t mon_e;
  int   mon_st;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;

  logic [31:0] regs [16];

  // Register file stub with one-cycle read latency
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) regs[i] <= 32'h0;
      regs[1] <= 32'hA5A5A5A5;
      regs[2] <= 32'h5A5A5A5A;
      rf_ra_data <= 32'h0;
      rf_rb_data <= 32'h0;
    end else begin
      rf_ra_data <= regs[rf_ra_addr];
      rf_rb_data <= regs[rf_rb_addr];
      if (rf_we) regs[rf_wa] <= rf_wd;
    end
  end

  // ARM ALU stub (carry = NOT borrow on subtraction)
  always_comb begin
    logic [31:0] x, y;
    logic        ci, lg;
    logic [32:0] s;
    x = operand_a; y = operand_b; ci = 1'b0; lg = 1'b0;
    result = 32'h0;
    case (alu_control)
      4'h2, 4'hA: begin y = ~operand_b; ci = 1'b1; end
      4'h3: begin x = operand_b; y = ~operand_a; ci = 1'b1; end
      4'h4, 4'hB: ci = 1'b0;
      4'h5: ci = alu_carry_in;
      4'h6: begin y = ~operand_b; ci = alu_carry_in; end
      4'h7: begin
        x = operand_b; y = ~operand_a; ci = alu_carry_in;
      end
      default: lg = 1'b1;
    endcase
    s = {1'b0, x} + {1'b0, y} + {32'h0, ci};
    case (alu_control)
      4'h0, 4'h8: result = operand_a & operand_b;
      4'h1, 4'h9: result = operand_a ^ operand_b;
      4'hC: result = operand_a | operand_b;
      4'hD: result = operand_b;
      4'hE: result = operand_a & ~operand_b;
      4'hF: result = ~operand_b;
      default: result = s[31:0];
    endcase
    negative_flag = result[31];
    zero_flag     = (result == 32'h0);
    carry_flag    = lg ? 1'b0 : s[32];
    overflow_flag = lg ? 1'b0
                  : ((x[31] == y[31]) && (s[31] != x[31]));
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Retire monitor: pops the scoreboard on every done
  always @(negedge clk) begin
    if (!rst) begin
      if (rf_we) chk("we_needs_done", {31'h0, done}, 32'h1);
      if (done) begin
        if (sb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_done: got done with empty scoreboard");
        end else begin
          mon_e  = sb.pop_front();
          mon_st = stamp_q.pop_front();
          chk("rf_we", {31'h0, rf_we}, {31'h0, mon_e.we});
          if (mon_e.we) begin
            chk("rf_wa", {28'h0, rf_wa}, {28'h0, mon_e.wa});
            chk("rf_wd", rf_wd, mon_e.wd);
          end
          chk("nzcv", {28'h0, nzcv}, {28'h0, mon_e.nzcv});
          chk("skipped", {31'h0, skipped}, {31'h0, mon_e.skp});
          chk("unsupported", {31'h0, unsupported},
              {31'h0, mon_e.uns});
          chk("latency", cyc - mon_st + 1, mon_e.lat);
        end
      end
    end
  end

  // Issue one instruction; entered and left on a negedge
  task automatic issue(input vec_t v);
    int n;
    n = 0;
    while (!instr_ready && n < 20) begin @(negedge clk); n++; end
    chk("ready_before_issue", {31'h0, instr_ready}, 32'h1);
    instr = v.instr;
    instr_valid = 1'b1;
    sb.push_back(v);
    stamp_q.push_back(cyc);
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);
    n = 0;
    while (!instr_ready && n < 20) begin @(negedge clk); n++; end
    chk("retired", sb.size(), 0);
    sb.delete();
    stamp_q.delete();
  endtask

  function automatic vec_t mk(input logic [31:0] i, input logic we,
                              input logic [3:0] wa,
                              input logic [31:0] wd,
                              input logic [3:0] f, input logic skp,
                              input logic uns, input int lat);
    vec_t v;
    v.instr = i; v.we = we; v.wa = wa; v.wd = wd;
    v.nzcv = f; v.skp = skp; v.uns = uns; v.lat = lat;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    instr_valid = 1'b0;
    instr = 32'h0;
    #1;
    chk("rst_ready", {31'h0, instr_ready}, 32'h1);
    chk("rst_nzcv", {28'h0, nzcv}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_we", {31'h0, rf_we}, 32'h0);
    chk("rst_wd", rf_wd, 32'h0);
    chk("rst_opb", operand_b, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    tbl.push_back(mk(32'hE0910002, 1, 4'h0, 32'hFFFFFFFF, 4'b1000, 0, 0, 4));
    tbl.push_back(mk(32'hE3A034FF, 1, 4'h3, 32'hFF000000, 4'b1000, 0, 0, 4));
    tbl.push_back(mk(32'hE1B060A1, 1, 4'h6, 32'h52D2D2D2, 4'b0010, 0, 0, 4));
    tbl.push_back(mk(32'hE0514001, 1, 4'h4, 32'h00000000, 4'b0110, 0, 0, 4));
    tbl.push_back(mk(32'h03A05001, 1, 4'h5, 32'h00000001, 4'b0110, 0, 0, 4));
    tbl.push_back(mk(32'hE3B07001, 1, 4'h7, 32'h00000001, 4'b0010, 0, 0, 4));
    tbl.push_back(mk(32'h03A05001, 0, 4'h5, 32'h0,        4'b0010, 1, 0, 3));
    tbl.push_back(mk(32'hE0810312, 0, 4'h0, 32'h0,        4'b0010, 0, 1, 3));
    tbl.push_back(mk(32'hE1410002, 0, 4'h0, 32'h0,        4'b0010, 0, 1, 3));
    tbl.push_back(mk(32'hE1510002, 0, 4'h0, 32'h0,        4'b0011, 0, 0, 4));
    tbl.push_back(mk(32'hF3A05001, 0, 4'h5, 32'h0,        4'b0011, 1, 0, 3));
    tbl.push_back(mk(32'hE5910000, 0, 4'h0, 32'h0,        4'b0011, 0, 1, 3));
    tbl.push_back(mk(32'hE1A08041, 1, 4'h8, 32'hFFFFFFFF, 4'b0011, 0, 0, 4));
    tbl.push_back(mk(32'hE1B09062, 1, 4'h9, 32'hAD2D2D2D, 4'b1001, 0, 0, 4));
    tbl.push_back(mk(32'hE1B0A021, 1, 4'hA, 32'h00000000, 4'b0111, 0, 0, 4));
    tbl.push_back(mk(32'hE0B1B002, 1, 4'hB, 32'h00000000, 4'b0110, 0, 0, 4));
    tbl.push_back(mk(32'hE3B0C102, 1, 4'hC, 32'h80000000, 4'b1010, 0, 0, 4));
    tbl.push_back(mk(32'hE1B0D081, 1, 4'hD, 32'h4B4B4B4A, 4'b0010, 0, 0, 4));
    tbl.push_back(mk(32'hE1A0E262, 1, 4'hE, 32'hA5A5A5A5, 4'b0010, 0, 0, 4));

    for (int i = 0; i < tbl.size(); i++) issue(tbl[i]);

    // Abort an ADDS in EXEC with reset
    instr = 32'hE0910002;
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("busy_in_exec", {31'h0, instr_ready}, 32'h0);
    rst = 1'b1;
    #1;
    chk("abort_ready", {31'h0, instr_ready}, 32'h1);
    chk("abort_nzcv", {28'h0, nzcv}, 32'h0);
    chk("abort_we", {31'h0, rf_we}, 32'h0);
    chk("abort_done", {31'h0, done}, 32'h0);
    @(negedge clk);
    chk("abort_we_hold", {31'h0, rf_we}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    issue(mk(32'hE0910002, 1, 4'h0, 32'hFFFFFFFF, 4'b1000, 0, 0, 4));
    issue(mk(32'h03A05001, 0, 4'h5, 32'h0, 4'b1000, 1, 0, 3));

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
